// File: rtl/diff_pkg.sv
// Shared types and defaults for the lowest-differing-bit scan controller.
package diff_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int IDXW_DEF  = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Mismatch count needs one extra bit so a full 32-bit mismatch does not wrap.
   typedef logic [IDXW_DEF:0] cnt_t;

endpackage

// File: rtl/diff_scan_ctrl_if.sv
// Operand capture, position stream and completion signals of diff_scan_ctrl.
interface diff_scan_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int IDXW  = 5
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_onehot;
   logic [IDXW-1:0]  out_index;
   logic             out_last;
   logic             done;
   logic [IDXW:0]    diff_count;
   logic             equal;

   modport master (
      output start, a, b, out_ready,
      input  busy, out_valid, out_onehot, out_index, out_last, done, diff_count, equal
   );

   modport slave (
      input  start, a, b, out_ready,
      output busy, out_valid, out_onehot, out_index, out_last, done, diff_count, equal
   );
endinterface

// File: rtl/diff_scan_ctrl_lsb_onehot_enc.sv
// Isolates the lowest set bit of a vector and encodes its position.
module lsb_onehot_enc #(
   parameter int WIDTH = 32,
   parameter int IDXW  = 5
) (
   input  logic [WIDTH-1:0] vec,
   output logic [WIDTH-1:0] onehot,
   output logic [IDXW-1:0]  index,
   output logic             single
);

   assign onehot = vec & (~vec + 1'b1);
   // Clearing the lowest bit leaves nothing when at most one bit is set.
   assign single = ((vec & (vec - 1'b1)) == '0);

   always_comb begin
      index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (onehot[i]) index = index | IDXW'(i);
      end
   end

endmodule

// File: rtl/diff_scan_ctrl.sv
// Captures two operands on start and streams each differing bit position, lowest first.
module diff_scan_ctrl
   import diff_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int IDXW  = IDXW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   diff_scan_ctrl_if.slave bus
);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] SCAN = ST_SCAN;
   localparam logic [1:0] DONE = ST_DONE;

   logic [1:0]       state;
   logic [WIDTH-1:0] pend;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] onehot;
   logic [IDXW-1:0]  index;
   logic             single;
   logic [IDXW:0]    cnt;
   logic [IDXW:0]    diff_count;
   logic             equal;
   logic             in_scan;

   assign diff = bus.a ^ bus.b;

   lsb_onehot_enc #(
      .WIDTH (WIDTH),
      .IDXW  (IDXW)
   ) u_enc (
      .vec    (pend),
      .onehot (onehot),
      .index  (index),
      .single (single)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pend       <= '0;
         cnt        <= '0;
         diff_count <= '0;
         equal      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  pend  <= diff;
                  cnt   <= '0;
                  state <= (diff == '0) ? DONE : SCAN;
               end
            end
            SCAN: begin
               if (bus.out_ready) begin
                  pend <= pend & ~onehot;
                  cnt  <= cnt + 1'b1;
                  if (single) state <= DONE;
               end
            end
            DONE: begin
               diff_count <= cnt;
               equal      <= (cnt == '0);
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Position outputs depend only on registered pend and state.
   assign in_scan        = (state == SCAN);
   assign bus.out_valid  = in_scan;
   assign bus.out_onehot = in_scan ? onehot : '0;
   assign bus.out_index  = in_scan ? index  : '0;
   assign bus.out_last   = in_scan & single;
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);
   assign bus.diff_count = diff_count;
   assign bus.equal      = equal;

endmodule

// File: tb/tb_diff_scan_ctrl.sv
// Directed self-checking bench for diff_scan_ctrl.
module tb_diff_scan_ctrl;
   import diff_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   diff_scan_ctrl_if #(.WIDTH(32), .IDXW(5)) bus ();

   diff_scan_ctrl #(.WIDTH(32), .IDXW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic launch(input logic [31:0] va, input logic [31:0] vb);
      bus.a     = va;
      bus.b     = vb;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
      n_chk++; if (bus.diff_count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.diff_count); end
      n_chk++; if (bus.equal !== 1'b0) begin n_fail++; $display("FAIL reset_equal: got %b want 0", bus.equal); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_scan();
      bus.out_ready = 1'b1;
      launch(32'hF, 32'h0);
      @(negedge clk);
      @(negedge clk);
      n_chk++; if (bus.out_index !== 5'd2) begin n_fail++; $display("FAIL midrst_pre_idx: got %0d want 2", bus.out_index); end
      rst_n = 1'b0;
      #1;
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
      n_chk++; if (bus.out_onehot !== 32'h0) begin n_fail++; $display("FAIL midrst_onehot: got %h want 0", bus.out_onehot); end
      n_chk++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL midrst_last: got %b want 0", bus.out_last); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_busy: got %b want 0", bus.busy); end
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_valid: got %b want 0", bus.out_valid); end
      n_chk++; if (bus.diff_count !== 6'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", bus.diff_count); end
   endtask

   task automatic test_equal();
      bus.out_ready = 1'b1;
      launch(32'hDEADBEEF, 32'hDEADBEEF);
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL eq_valid: got %b want 0", bus.out_valid); end
      n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL eq_done: got %b want 1", bus.done); end
      n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL eq_busy: got %b want 1", bus.busy); end
      @(negedge clk);
      n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL eq_done_pulse: got %b want 0", bus.done); end
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL eq_idle: got %b want 0", bus.busy); end
      n_chk++; if (bus.diff_count !== 6'd0) begin n_fail++; $display("FAIL eq_count: got %0d want 0", bus.diff_count); end
      n_chk++; if (bus.equal !== 1'b1) begin n_fail++; $display("FAIL eq_equal: got %b want 1", bus.equal); end
   endtask

   task automatic test_sparse();
      cnt_t exp_cnt;
      exp_cnt = 6'd2;
      bus.out_ready = 1'b1;
      launch(32'h8000_0011, 32'h0000_0001);
      n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sp_valid0: got %b want 1", bus.out_valid); end
      n_chk++; if (bus.out_index !== 5'd4) begin n_fail++; $display("FAIL sp_idx0: got %0d want 4", bus.out_index); end
      n_chk++; if (bus.out_onehot !== 32'h10) begin n_fail++; $display("FAIL sp_oh0: got %h want 00000010", bus.out_onehot); end
      n_chk++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL sp_last0: got %b want 0", bus.out_last); end
      @(negedge clk);
      n_chk++; if (bus.out_index !== 5'd31) begin n_fail++; $display("FAIL sp_idx1: got %0d want 31", bus.out_index); end
      n_chk++; if (bus.out_onehot !== 32'h8000_0000) begin n_fail++; $display("FAIL sp_oh1: got %h want 80000000", bus.out_onehot); end
      n_chk++; if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL sp_last1: got %b want 1", bus.out_last); end
      @(negedge clk);
      n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL sp_done: got %b want 1", bus.done); end
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sp_valid_done: got %b want 0", bus.out_valid); end
      @(negedge clk);
      n_chk++; if (bus.diff_count !== exp_cnt) begin n_fail++; $display("FAIL sp_count: got %0d want %0d", bus.diff_count, exp_cnt); end
      n_chk++; if (bus.equal !== 1'b0) begin n_fail++; $display("FAIL sp_equal: got %b want 0", bus.equal); end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      launch(32'h6, 32'h0);
      for (int i = 0; i < 3; i++) begin
         n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d: got %b want 1", i, bus.out_valid); end
         n_chk++; if (bus.out_index !== 5'd1) begin n_fail++; $display("FAIL bp_idx%0d: got %0d want 1", i, bus.out_index); end
         n_chk++; if (bus.out_onehot !== 32'h2) begin n_fail++; $display("FAIL bp_oh%0d: got %h want 00000002", i, bus.out_onehot); end
         if (i == 2) bus.out_ready = 1'b1;
         @(negedge clk);
      end
      n_chk++; if (bus.out_index !== 5'd2) begin n_fail++; $display("FAIL bp_idx_next: got %0d want 2", bus.out_index); end
      n_chk++; if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL bp_last: got %b want 1", bus.out_last); end
      @(negedge clk);
      n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b want 1", bus.done); end
      @(negedge clk);
      n_chk++; if (bus.diff_count !== 6'd2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", bus.diff_count); end
   endtask

   task automatic test_full_mismatch();
      logic [31:0] exp_oh;
      bus.out_ready = 1'b1;
      launch(32'hFFFF_FFFF, 32'h0);
      for (int i = 0; i < 32; i++) begin
         exp_oh = 32'h1 << i;
         n_chk++; if (bus.out_index !== 5'(i)) begin n_fail++; $display("FAIL full_idx%0d: got %0d want %0d", i, bus.out_index, i); end
         n_chk++; if (bus.out_onehot !== exp_oh) begin n_fail++; $display("FAIL full_oh%0d: got %h want %h", i, bus.out_onehot, exp_oh); end
         n_chk++; if (bus.out_last !== (i == 31)) begin n_fail++; $display("FAIL full_last%0d: got %b want %b", i, bus.out_last, (i == 31)); end
         @(negedge clk);
      end
      n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b want 1", bus.done); end
      @(negedge clk);
      n_chk++; if (bus.diff_count !== 6'b100000) begin n_fail++; $display("FAIL full_count: got %0d want 32", bus.diff_count); end
      n_chk++; if (bus.equal !== 1'b0) begin n_fail++; $display("FAIL full_equal: got %b want 0", bus.equal); end
   endtask

   task automatic test_busy_start();
      bus.out_ready = 1'b1;
      launch(32'h0000_0101, 32'h0);
      n_chk++; if (bus.out_index !== 5'd0) begin n_fail++; $display("FAIL bs_idx0: got %0d want 0", bus.out_index); end
      bus.a = 32'hFFFF_0000; bus.b = 32'h0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_chk++; if (bus.out_index !== 5'd8) begin n_fail++; $display("FAIL bs_idx1: got %0d want 8", bus.out_index); end
      n_chk++; if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL bs_last: got %b want 1", bus.out_last); end
      @(negedge clk);
      n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL bs_done: got %b want 1", bus.done); end
      bus.a = 32'h1; bus.b = 32'h0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bs_done_start_busy: got %b want 0", bus.busy); end
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bs_done_start_valid: got %b want 0", bus.out_valid); end
      n_chk++; if (bus.diff_count !== 6'd2) begin n_fail++; $display("FAIL bs_count: got %0d want 2", bus.diff_count); end
      @(negedge clk);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_reset_mid_scan();
      test_equal();
      test_sparse();
      test_backpressure();
      test_full_mismatch();
      test_busy_start();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
